// File: rtl/alu_muldiv.sv
// Single-issue integer ALU with iterative multiply/divide (one bit per cycle).
// Simple ops and divide corner cases complete in one cycle; MUL/DIV ops take XLEN+1.
module alu_muldiv #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [1:0]      o_dbg_state
);

  // Handshakes: a request transfers on a rising edge where in_valid && in_ready;
  // a result transfers where out_valid && out_ready. out_valid/result hold until then.

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4,  OP_SLL = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
  localparam logic [4:0] OP_SLT = 5'd8,  OP_SLTU = 5'd9, OP_AUIPC = 5'd10, OP_LUI = 5'd11;
  localparam logic [4:0] OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
  localparam logic [4:0] OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22,   OP_REMU = 5'd23;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          r_state;
  logic            r_live;
  logic [4:0]      r_op;
  logic [SHW-1:0]  r_cnt;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opnd;
  logic            r_neg;
  logic            r_neg_rem;
  logic [XLEN-1:0] r_result;

  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu;
  logic            w_accept;
  logic            w_is_md;
  logic            w_is_div;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_iter;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_hi_n;
  logic [XLEN-1:0] w_lo_n;
  logic [2*XLEN-1:0] w_prod_raw;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_md_res;
  logic            w_last;

  // r_live keeps in_ready low while reset is held and until the first edge after release.
  assign in_ready    = (r_state == IDLE) && r_live;
  assign out_valid   = (r_state == DONE);
  assign result      = r_result;
  assign o_dbg_state = r_state;
  assign w_accept    = in_valid && in_ready;

  assign w_shamt    = op_b[SHW-1:0];
  assign w_is_md    = (op[4:3] == 2'b10);
  assign w_is_div   = w_is_md && op[2];
  assign w_div_zero = (op_b == '0);
  assign w_div_ovf  = w_is_div && !op[0] && (op_a == MOST_NEG) && (op_b == '1);
  assign w_iter     = w_is_md && !(w_is_div && (w_div_zero || w_div_ovf));
  assign w_a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                      (op == OP_DIV) || (op == OP_REM);
  assign w_b_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign w_a_neg    = w_a_signed && op_a[XLEN-1];
  assign w_b_neg    = w_b_signed && op_b[XLEN-1];
  assign w_a_mag    = w_a_neg ? -op_a : op_a;
  assign w_b_mag    = w_b_neg ? -op_b : op_b;

  always_comb begin
    w_alu = '0;
    case (op)
      OP_ADD:   w_alu = op_a + op_b;
      OP_SUB:   w_alu = op_a - op_b;
      OP_AND:   w_alu = op_a & op_b;
      OP_OR:    w_alu = op_a | op_b;
      OP_XOR:   w_alu = op_a ^ op_b;
      OP_SLL:   w_alu = op_a << w_shamt;
      OP_SRL:   w_alu = op_a >> w_shamt;
      OP_SRA:   w_alu = $signed(op_a) >>> w_shamt;
      OP_SLT:   w_alu = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU:  w_alu = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_AUIPC: w_alu = op_a + (op_b << 12);
      OP_LUI:   w_alu = op_b << 12;
      // Only reached for divide-by-zero or signed overflow; normal divides iterate.
      OP_DIV, OP_DIVU: w_alu = w_div_zero ? '1 : op_a;
      OP_REM, OP_REMU: w_alu = w_div_zero ? op_a : '0;
      default:  w_alu = '0;
    endcase
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  assign w_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : '0)};
  assign w_trial = {r_hi, r_lo[XLEN-1]} - {1'b0, r_opnd};

  always_comb begin
    w_hi_n = '0;
    w_lo_n = '0;
    if (!r_op[2]) begin
      {w_hi_n, w_lo_n} = {w_sum, r_lo[XLEN-1:1]};
    end else if (!w_trial[XLEN]) begin
      w_hi_n = w_trial[XLEN-1:0];
      w_lo_n = {r_lo[XLEN-2:0], 1'b1};
    end else begin
      w_hi_n = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
      w_lo_n = {r_lo[XLEN-2:0], 1'b0};
    end
  end

  assign w_prod_raw = {w_hi_n, w_lo_n};
  assign w_prod     = r_neg ? -w_prod_raw : w_prod_raw;
  assign w_quo      = r_neg ? -w_lo_n : w_lo_n;
  assign w_rem      = r_neg_rem ? -w_hi_n : w_hi_n;
  assign w_last     = (r_cnt == SHW'(XLEN - 1));

  always_comb begin
    w_md_res = '0;
    case ({r_op[2], r_op[1:0] == 2'b00, r_op[1]})
      3'b010, 3'b011:  w_md_res = w_prod[XLEN-1:0];
      3'b000, 3'b001:  w_md_res = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b110:  w_md_res = w_quo;
      default:         w_md_res = w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_live    <= 1'b0;
      r_op      <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opnd    <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
    end else begin
      r_live <= 1'b1;
      if (flush) begin
        r_state  <= IDLE;
        r_cnt    <= '0;
        r_result <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_op <= op;
              if (w_iter) begin
                r_state   <= BUSY;
                r_cnt     <= '0;
                r_hi      <= '0;
                r_lo      <= w_is_div ? w_a_mag : w_b_mag;
                r_opnd    <= w_is_div ? w_b_mag : w_a_mag;
                r_neg     <= w_a_neg ^ w_b_neg;
                r_neg_rem <= w_a_neg;
              end else begin
                r_state  <= DONE;
                r_result <= w_alu;
              end
            end
          end
          BUSY: begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            r_cnt <= r_cnt + SHW'(1);
            if (w_last) begin
              r_state  <= DONE;
              r_cnt    <= '0;
              r_result <= w_md_res;
            end
          end
          DONE: begin
            if (out_ready) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: XLEN=32 and XLEN=64 instances, expected results
// queued at issue time and checked by independent output monitors.
module tb_alu_muldiv;

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, AND_ = 5'd2, OR_ = 5'd3, XOR_ = 5'd4;
  localparam logic [4:0] SLL = 5'd5, SRL = 5'd6, SRA = 5'd7, SLT = 5'd8, SLTU = 5'd9;
  localparam logic [4:0] AUIPC = 5'd10, LUI = 5'd11, MUL = 5'd16, MULH = 5'd17;
  localparam logic [4:0] MULHSU = 5'd18, MULHU = 5'd19, DIV = 5'd20, DIVU = 5'd21;
  localparam logic [4:0] REM = 5'd22, REMU = 5'd23;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_BUSY = 2'd1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  op;
  logic [31:0] op_a, op_b, result;
  logic [1:0]  dbg_state;

  logic        flush64, in_valid64, in_ready64, out_valid64, out_ready64;
  logic [4:0]  op64;
  logic [63:0] op_a64, op_b64, result64;
  logic [1:0]  dbg_state64;

  alu_muldiv #(.XLEN(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .o_dbg_state(dbg_state)
  );

  alu_muldiv #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush64), .in_valid(in_valid64), .in_ready(in_ready64),
    .op(op64), .op_a(op_a64), .op_b(op_b64), .out_valid(out_valid64), .out_ready(out_ready64),
    .result(result64), .o_dbg_state(dbg_state64)
  );

  // scoreboard
  int n_checks = 0;
  int n_miss   = 0;
  logic [31:0] exp_q[$];
  int          acc_q[$];
  int          lat_q[$];
  logic [63:0] exp64_q[$];
  int          acc64_q[$];
  int          lat64_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic        seen32 = 1'b0;
  int          first32 = 0;
  logic [31:0] held32 = '0;
  always begin
    @(negedge clk); #1;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid32", 64'd1, 64'd0);
      end else begin
        if (!seen32) begin
          seen32  = 1'b1;
          first32 = cyc;
          held32  = result;
        end else begin
          check("result_stable32", 64'(result), 64'(held32));
        end
        if (out_ready) begin
          check("result32", 64'(result), 64'(exp_q.pop_front()));
          check("latency32", 64'(first32 - acc_q.pop_front()), 64'(lat_q.pop_front()));
          seen32 = 1'b0;
        end
      end
    end else begin
      seen32 = 1'b0;
    end
  end

  logic seen64 = 1'b0;
  int   first64 = 0;
  always begin
    @(negedge clk); #1;
    if (rst_n && out_valid64) begin
      if (exp64_q.size() == 0) begin
        check("unexpected_out_valid64", 64'd1, 64'd0);
      end else begin
        if (!seen64) begin
          seen64  = 1'b1;
          first64 = cyc;
        end
        if (out_ready64) begin
          check("result64", result64, exp64_q.pop_front());
          check("latency64", 64'(first64 - acc64_q.pop_front()), 64'(lat64_q.pop_front()));
          seen64 = 1'b0;
        end
      end
    end else begin
      seen64 = 1'b0;
    end
  end

  // driver tasks
  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input int lat, input bit push);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout32", 64'd0, 64'd1);
      return;
    end
    op = o; op_a = a; op_b = b; in_valid = 1'b1;
    if (push) begin
      exp_q.push_back(e);
      acc_q.push_back(cyc);
      lat_q.push_back(lat);
    end
    @(negedge clk);
    in_valid = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
  endtask

  task automatic issue64(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] e, input int lat);
    int guard = 0;
    @(negedge clk);
    while (!in_ready64 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready64) begin
      check("in_ready_timeout64", 64'd0, 64'd1);
      return;
    end
    op64 = o; op_a64 = a; op_b64 = b; in_valid64 = 1'b1;
    exp64_q.push_back(e);
    acc64_q.push_back(cyc);
    lat64_q.push_back(lat);
    @(negedge clk);
    in_valid64 = 1'b0;
    op_a64 = {$urandom, $urandom};
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || exp64_q.size() != 0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain32", 64'(exp_q.size()), 64'd0);
    check("drain64", 64'(exp64_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = '0; op_a = '0; op_b = '0; out_ready = 1'b1;
    flush64 = 1'b0; in_valid64 = 1'b0; op64 = '0; op_a64 = '0; op_b64 = '0; out_ready64 = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    #1 check("release_in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("release_in_ready_after_edge", 64'(in_ready), 64'd1);

    // single-cycle ALU ops
    issue(ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1);
    issue(SRA,   32'h80000000, 32'h00000024, 32'hF8000000, 1, 1);
    issue(SUB,   32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1, 1);
    issue(AND_,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1, 1);
    issue(OR_,   32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 1, 1);
    issue(XOR_,  32'hAAAAAAAA, 32'hFFFF0000, 32'h5555AAAA, 1, 1);
    issue(SLL,   32'h00000001, 32'h0000003F, 32'h80000000, 1, 1);
    issue(SRL,   32'h80000000, 32'h00000004, 32'h08000000, 1, 1);
    issue(SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1, 1);
    issue(SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1);
    issue(AUIPC, 32'h00001000, 32'h00012345, 32'h12346000, 1, 1);
    issue(LUI,   32'h12345678, 32'h000ABCDE, 32'hABCDE000, 1, 1);
    issue(5'd12, 32'h12345678, 32'h11111111, 32'h00000000, 1, 1);
    issue(5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 1);

    // iterative multiply / divide
    issue(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 1);
    issue(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1);
    issue(MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1);
    issue(MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33, 1);
    issue(MULH,   32'h80000000, 32'h00000002, 32'hFFFFFFFF, 33, 1);
    issue(MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 1);
    issue(DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, 1);
    issue(REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33, 1);
    issue(DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, 1);
    issue(REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33, 1);
    issue(REMU,   32'h00000064, 32'h00000007, 32'h00000002, 33, 1);

    // divide corner cases complete in one cycle
    issue(DIVU, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1, 1);
    issue(REMU, 32'h00000005, 32'h00000000, 32'h00000005, 1, 1);
    issue(REM,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1, 1);
    issue(DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1);
    issue(REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1);
    wait_drain();

    // backpressure: result held, no new request accepted
    out_ready = 1'b0;
    issue(DIVU, 32'd100, 32'd7, 32'd14, 33, 1);
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("bp_out_valid_reached", 64'(out_valid), 64'd1);
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_out_valid_held", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_state_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("bp_in_ready_after", 64'(in_ready), 64'd1);

    // flush in BUSY cycle 5 drops the operation
    issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 0, 0);
    repeat (4) @(negedge clk);
    check("flush_pre_state_busy", 64'(dbg_state), 64'(ST_BUSY));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_result_cleared", 64'(result), 64'd0);
    repeat (40) @(negedge clk);

    // flush wins over a simultaneous request
    op = ADD; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_prio_state", 64'(dbg_state), 64'(ST_IDLE));
    check("flush_prio_in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(negedge clk);
    issue(ADD, 32'd2, 32'd3, 32'd5, 1, 1);
    wait_drain();

    // reset in the middle of a divide
    issue(DIV, 32'hFFFFFFF9, 32'h00000002, 32'h0, 0, 0);
    repeat (5) @(negedge clk);
    check("mid_div_state_busy", 64'(dbg_state), 64'(ST_BUSY));
    check("mid_div_result_held", 64'(result), 64'd5);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_result", 64'(result), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd0);
    check("async_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rerelease_in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("rerelease_in_ready_after_edge", 64'(in_ready), 64'd1);
    repeat (40) @(negedge clk);
    check("rerelease_state_idle", 64'(dbg_state), 64'(ST_IDLE));

    // XLEN=64 instance
    issue64(DIVU,  64'h8000000000000000, 64'd3, 64'h2AAAAAAAAAAAAAAA, 65);
    issue64(REMU,  64'h8000000000000000, 64'd3, 64'd2, 65);
    issue64(MULHU, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 65);
    issue64(DIV,   64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1);
    issue64(SRA,   64'h8000000000000000, 64'h0000000000000044, 64'hF800000000000000, 1);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount width; not overridden by instantiators.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous abort of any operation in flight.
REQ-006 SHALL have port in_valid  input  1  request presents operands and opcode.
REQ-007 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-008 SHALL have port op  input  5  operation selector (encoding REQ-013).
REQ-009 SHALL have port op_a  input  XLEN  operand A.
REQ-010 SHALL have port op_b  input  XLEN  operand B.
REQ-011 SHALL have port out_valid  output  1  result valid and held stable.
REQ-012 SHALL have ports out_ready  input  1  consumer accepts result; result  output  XLEN  result data.

Function
REQ-013 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 AUIPC (a+(b<<12)), 11 LUI (b<<12), 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU; all others result 0.
REQ-014 Shifts SHALL use op_b[SHW-1:0] only; SLT/SLTU results SHALL be zero-extended 0/1; all arithmetic modulo 2^XLEN.
REQ-015 State machine SHALL have states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE and not in reset.
REQ-016 Request accepted when in_valid && in_ready; op, op_a, op_b SHALL be registered on acceptance; inputs ignored otherwise.
REQ-017 Ops 0-11 and unlisted opcodes: IDLE->DONE; out_valid SHALL assert the cycle after acceptance (latency 1).
REQ-018 Ops 16-23: IDLE->BUSY; iterative shift-add multiply / restoring divide, one bit per cycle, XLEN iterations counted by a 0..XLEN-1 counter; BUSY->DONE after final iteration; out_valid latency XLEN+1 cycles.
REQ-019 MULH/MULHSU/MULHU SHALL return upper XLEN bits of the 2*XLEN product with signed*signed, signed*unsigned, unsigned*unsigned operands; MUL returns lower XLEN bits.
REQ-020 Signed divide SHALL operate on magnitudes and correct signs: quotient negative iff signs differ, remainder takes dividend's sign.
REQ-021 Divide by zero SHALL take latency 1 (IDLE->DONE): DIV/DIVU quotient all-ones, REM/REMU remainder = op_a.
REQ-022 Signed overflow (op_a = most negative, op_b = -1) SHALL take latency 1: DIV quotient = op_a, REM remainder 0.
REQ-023 In DONE, out_valid=1 and result SHALL hold stable until out_ready; on out_valid && out_ready state SHALL return to IDLE; in_ready rises the following cycle (no same-cycle accept).
REQ-024 flush SHALL force IDLE next cycle from any state, drop the result, clear out_valid; flush has priority over acceptance and completion in the same cycle.
REQ-025 out_valid SHALL be 0 in IDLE and BUSY.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, counter 0, out_valid 0, result 0, in_ready 0 while asserted.
REQ-027 Deassertion mid-operation SHALL leave no residual operation; in_ready=1 first rising edge after release.

Verification
REQ-028 ADD a=0xFFFFFFFF, b=1, out_ready=1 -> out_valid one cycle later, result 0x00000000; SRA a=0x80000000, b=0x24 -> 0xF8000000.
REQ-029 MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0x00000000 after 33 cycles; MULHU same operands -> 0xFFFFFFFE; MUL a=7, b=-3 -> 0xFFFFFFEB.
REQ-030 DIV a=-7, b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=5, b=0 -> 0xFFFFFFFF at latency 1; DIV a=0x80000000, b=-1 -> 0x80000000.
REQ-031 Backpressure: DIVU 100/7 with out_ready=0 for 10 cycles -> result 14 held stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-032 flush asserted at BUSY cycle 5 of MULHU -> no out_valid ever for that op, in_ready=1 next cycle; next ADD 2+3 returns 5.
REQ-033 rst_n pulsed low mid-DIV -> out_valid, result 0 immediately; after release, XLEN=64 build: DIVU 2^63/3 returns 0x2AAAAAAAAAAAAAAA after 65 cycles.
